// File: rtl/car_pulse_generator.sv
// Drives the botonA/botonB sensor lines through one four-phase entry or exit
// pattern on command, with a programmable dwell per phase.
module car_pulse_generator #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_entrada,
    input  logic             start_salida,
    input  logic [CNT_W-1:0] dwell,
    output logic             botonA,
    output logic             botonB,
    output logic             busy,
    output logic             done,
    output logic             dir
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dwell_lat;
    logic             phase_end;

    // dwell_lat is never zero, so the subtraction cannot underflow
    assign phase_end = (cnt == (dwell_lat - ONE));

    // Pattern sequencer: state, dwell counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= ZERO;
            dwell_lat <= ONE;
            botonA    <= 1'b0;
            botonB    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= ZERO;
                    botonA <= 1'b0;
                    botonB <= 1'b0;
                    busy   <= 1'b0;
                    if (start_entrada ^ start_salida) begin
                        state     <= P1;
                        dir       <= start_entrada;
                        dwell_lat <= (dwell == ZERO) ? ONE : dwell;
                        busy      <= 1'b1;
                        // Entry opens with A only, exit with B only
                        botonA    <= start_entrada;
                        botonB    <= start_salida;
                    end
                end
                P1: begin
                    if (phase_end) begin
                        state  <= P2;
                        cnt    <= ZERO;
                        botonA <= 1'b1;
                        botonB <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                P2: begin
                    if (phase_end) begin
                        state  <= P3;
                        cnt    <= ZERO;
                        botonA <= ~dir;
                        botonB <= dir;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                P3: begin
                    if (phase_end) begin
                        state  <= GAP;
                        cnt    <= ZERO;
                        botonA <= 1'b0;
                        botonB <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        state <= IDLE;
                        cnt   <= ZERO;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= ZERO;
                    botonA <= 1'b0;
                    botonB <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_car_pulse_generator.sv
// Directed bench for car_pulse_generator, with a small behavioural
// entry/exit detector watching the generated sensor lines.
module tb_car_pulse_generator;

    localparam int CNT_W = 26;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_entrada = 1'b0;
    logic             start_salida = 1'b0;
    logic [CNT_W-1:0] dwell = '0;
    logic             botonA, botonB, busy, done, dir;

    int errors = 0;
    int checks = 0;

    car_pulse_generator #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .start_entrada(start_entrada), .start_salida(start_salida),
        .dwell(dwell),
        .botonA(botonA), .botonB(botonB),
        .busy(busy), .done(done), .dir(dir)
    );

    always #5 clk = ~clk;

    // Behavioural detector: recognises 10,11,01,00 (entry) and 01,11,10,00 (exit)
    logic [1:0] ent_s = 2'd0;
    logic [1:0] sal_s = 2'd0;
    int ent_cnt = 0, sal_cnt = 0, ent_gap = 0, sal_gap = 0;
    time ent_time = 0, sal_time = 0;

    always @(posedge clk) begin
        case (ent_s)
            2'd0: if ({botonA, botonB} == 2'b10) ent_s <= 2'd1;
            2'd1: if ({botonA, botonB} == 2'b11) ent_s <= 2'd2;
                  else if ({botonA, botonB} == 2'b00) ent_s <= 2'd0;
            2'd2: if ({botonA, botonB} == 2'b01) ent_s <= 2'd3;
                  else if ({botonA, botonB} == 2'b00) ent_s <= 2'd0;
            default: if ({botonA, botonB} == 2'b00) begin
                ent_s <= 2'd0;
                ent_cnt <= ent_cnt + 1;
                ent_time <= $time;
                if (busy) ent_gap <= ent_gap + 1;
            end
        endcase
        case (sal_s)
            2'd0: if ({botonA, botonB} == 2'b01) sal_s <= 2'd1;
            2'd1: if ({botonA, botonB} == 2'b11) sal_s <= 2'd2;
                  else if ({botonA, botonB} == 2'b00) sal_s <= 2'd0;
            2'd2: if ({botonA, botonB} == 2'b10) sal_s <= 2'd3;
                  else if ({botonA, botonB} == 2'b00) sal_s <= 2'd0;
            default: if ({botonA, botonB} == 2'b00) begin
                sal_s <= 2'd0;
                sal_cnt <= sal_cnt + 1;
                sal_time <= $time;
                if (busy) sal_gap <= sal_gap + 1;
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {dir, botonA, botonB, busy, done};
    endfunction

    // Expected {dir,A,B,busy,done} k cycles after a start of direction e with dwell d
    function automatic logic [4:0] model(input logic e, input int d, input int k);
        int de;
        int ph;
        logic [1:0] ab;
        de = (d == 0) ? 1 : d;
        if (k >= 1 && k <= 4 * de) begin
            ph = (k - 1) / de;
            case (ph)
                0:       ab = e ? 2'b10 : 2'b01;
                1:       ab = 2'b11;
                2:       ab = e ? 2'b01 : 2'b10;
                default: ab = 2'b00;
            endcase
            return {e, ab, 1'b1, 1'b0};
        end else if (k == 4 * de + 1) begin
            return {e, 4'b0001};
        end
        return {e, 4'b0000};
    endfunction

    logic [4:0] tbl_ent [1:10];
    logic [4:0] tbl_sal [1:6];
    int e0, s0, eg0, sg0;

    initial begin
        tbl_ent[1] = 5'b11010; tbl_ent[2] = 5'b11010;
        tbl_ent[3] = 5'b11110; tbl_ent[4] = 5'b11110;
        tbl_ent[5] = 5'b10110; tbl_ent[6] = 5'b10110;
        tbl_ent[7] = 5'b10010; tbl_ent[8] = 5'b10010;
        tbl_ent[9] = 5'b10001; tbl_ent[10] = 5'b10000;
        tbl_sal[1] = 5'b00110; tbl_sal[2] = 5'b01110;
        tbl_sal[3] = 5'b01010; tbl_sal[4] = 5'b00010;
        tbl_sal[5] = 5'b00001; tbl_sal[6] = 5'b00000;

        // Reset state
        step(); step();
        chk("reset", outs(), 5'b00000);
        rst = 1'b0;
        step();
        chk("idle_after_reset", outs(), 5'b00000);

        // Entry, dwell 2
        dwell = 26'd2;
        start_entrada = 1'b1;
        step();
        start_entrada = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("entry_d2_c%0d", k), outs(), tbl_ent[k]);
            step();
        end

        // Exit, dwell 0 treated as 1
        dwell = 26'd0;
        start_salida = 1'b1;
        step();
        start_salida = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("exit_d0_c%0d", k), outs(), tbl_sal[k]);
            step();
        end

        // Both starts together are ignored; dir stays 0 from the exit
        dwell = 26'd2;
        start_entrada = 1'b1;
        start_salida = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("both_c%0d", k), outs(), 5'b00000);
        end
        start_entrada = 1'b0;
        start_salida = 1'b0;
        step();
        chk("both_after", outs(), 5'b00000);

        // Entry dwell 3; dwell changed in P1, exit start during P2
        dwell = 26'd3;
        start_entrada = 1'b1;
        step();
        start_entrada = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            chk($sformatf("entry_d3_c%0d", k), outs(), model(1'b1, 3, k));
            if (k == 2) dwell = 26'd9;
            if (k == 5) start_salida = 1'b1;
            if (k == 6) start_salida = 1'b0;
            step();
        end

        // Reset in the second cycle of P2, dwell 4
        dwell = 26'd4;
        start_entrada = 1'b1;
        step();
        start_entrada = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("abort_c%0d", k), outs(), model(1'b1, 4, k));
            if (k < 6) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_reset", outs(), 5'b00000);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k % 5 == 0) chk($sformatf("abort_idle_%0d", k), outs(), 5'b00000);
        end

        // Loop-back: entry then exit back-to-back, dwell 5
        e0 = ent_cnt; s0 = sal_cnt; eg0 = ent_gap; sg0 = sal_gap;
        dwell = 26'd5;
        start_entrada = 1'b1;
        step();
        start_entrada = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            chk($sformatf("loop_ent_c%0d", k), outs(), model(1'b1, 5, k));
            if (k < 21) step();
        end
        start_salida = 1'b1;
        step();
        start_salida = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            chk($sformatf("loop_sal_c%0d", k), outs(), model(1'b0, 5, k));
            step();
        end
        step(); step();
        chk("det_entrada_count", 5'(ent_cnt - e0), 5'd1);
        chk("det_salida_count", 5'(sal_cnt - s0), 5'd1);
        chk("det_entrada_in_gap", 5'(ent_gap - eg0), 5'd1);
        chk("det_salida_in_gap", 5'(sal_gap - sg0), 5'd1);
        chk("det_order", {4'b0000, ent_time < sal_time}, 5'b00001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
